// File: rtl/jesd204_ilas_pkg.sv
// ----------------------------------------------------------------------------
// jesd204_ilas_pkg
// Shared definitions for the JESD204 ILAS configuration multiframe (2nd
// multiframe of the ILAS): octet indices, field bit positions, lane FSM state
// type, the FCHK checksum and the expected-octet builder. The builder is the
// same function the TX static config generator uses. Both sides therefore
// agree on the packing by construction.
//
// Octet vectors are packed with octet 0 in bits [7:0].
// ----------------------------------------------------------------------------
package jesd204_ilas_pkg;

  localparam int ILAS_NUM_OCTETS = 14;

  // Octet indices within the configuration multiframe
  localparam int ILAS_OCT_DID          = 0;
  localparam int ILAS_OCT_BID          = 1;   // {ADJCNT, BID}
  localparam int ILAS_OCT_LID          = 2;   // {-, ADJDIR, PHADJ, LID}
  localparam int ILAS_OCT_SCR_L        = 3;   // {SCR, 2'b0, L-1}
  localparam int ILAS_OCT_F            = 4;
  localparam int ILAS_OCT_K            = 5;
  localparam int ILAS_OCT_M            = 6;
  localparam int ILAS_OCT_CS_N         = 7;   // {CS, 1'b0, N-1}
  localparam int ILAS_OCT_SUBCLASS_NP  = 8;   // {SUBCLASSV, NP-1}
  localparam int ILAS_OCT_JESDV_S      = 9;   // {JESDV, S-1}
  localparam int ILAS_OCT_HD_CF        = 10;  // {HD, 2'b0, CF}
  localparam int ILAS_OCT_RES1         = 11;
  localparam int ILAS_OCT_RES2         = 12;
  localparam int ILAS_OCT_FCHK         = 13;

  // Field bit positions inside their octets
  localparam int ILAS_ADJCNT_LSB    = 4;
  localparam int ILAS_PHADJ_BIT     = 5;
  localparam int ILAS_ADJDIR_BIT    = 6;
  localparam int ILAS_SCR_BIT       = 7;
  localparam int ILAS_CS_LSB        = 6;
  localparam int ILAS_SUBCLASSV_LSB = 5;
  localparam int ILAS_JESDV_LSB     = 5;
  localparam int ILAS_HD_BIT        = 7;

  typedef logic [ILAS_NUM_OCTETS*8-1:0] ilas_octets_t;

  typedef enum logic [1:0] {
    ILAS_IDLE    = 2'd0,
    ILAS_CAPTURE = 2'd1,
    ILAS_CHECK   = 2'd2,
    ILAS_DONE    = 2'd3
  } ilas_lane_state_e;

  // Wrapping 8-bit sum of the field values (not the raw octets) carried in
  // octets 0..10. Reserved octets and the FCHK octet itself are excluded.
  function automatic logic [7:0] ilas_fchk(input ilas_octets_t oct);
    logic [7:0] o [ILAS_NUM_OCTETS];
    logic [7:0] sum;
    for (int i = 0; i < ILAS_NUM_OCTETS; i++) begin
      o[i] = oct[i*8 +: 8];
    end
    sum = o[ILAS_OCT_DID]
        + {4'b0, o[ILAS_OCT_BID][3:0]}
        + {4'b0, o[ILAS_OCT_BID][ILAS_ADJCNT_LSB +: 4]}
        + {3'b0, o[ILAS_OCT_LID][4:0]}
        + {7'b0, o[ILAS_OCT_LID][ILAS_PHADJ_BIT]}
        + {7'b0, o[ILAS_OCT_LID][ILAS_ADJDIR_BIT]}
        + {7'b0, o[ILAS_OCT_SCR_L][ILAS_SCR_BIT]}
        + {3'b0, o[ILAS_OCT_SCR_L][4:0]}
        + o[ILAS_OCT_F]
        + {3'b0, o[ILAS_OCT_K][4:0]}
        + o[ILAS_OCT_M]
        + {6'b0, o[ILAS_OCT_CS_N][ILAS_CS_LSB +: 2]}
        + {3'b0, o[ILAS_OCT_CS_N][4:0]}
        + {5'b0, o[ILAS_OCT_SUBCLASS_NP][ILAS_SUBCLASSV_LSB +: 3]}
        + {3'b0, o[ILAS_OCT_SUBCLASS_NP][4:0]}
        + {5'b0, o[ILAS_OCT_JESDV_S][ILAS_JESDV_LSB +: 3]}
        + {3'b0, o[ILAS_OCT_JESDV_S][4:0]}
        + {7'b0, o[ILAS_OCT_HD_CF][ILAS_HD_BIT]}
        + {3'b0, o[ILAS_OCT_HD_CF][4:0]};
    return sum;
  endfunction

  // Expected configuration octets for one lane. ADJCNT/PHADJ/ADJDIR, CS, CF
  // are 0, JESDV is 1 and S is 1; FCHK is filled in from the other fields.
  function automatic ilas_octets_t ilas_build_octets(
    input logic [7:0] did,
    input logic [3:0] bid,
    input logic [4:0] lid,
    input int         num_lanes,
    input int         f,
    input int         k,
    input int         m,
    input int         n,
    input int         np,
    input logic       scr,
    input logic       hd,
    input logic [2:0] subclassv
  );
    ilas_octets_t o;
    o = '0;
    o[ILAS_OCT_DID*8 +: 8]         = did;
    o[ILAS_OCT_BID*8 +: 8]         = {4'b0, bid};
    o[ILAS_OCT_LID*8 +: 8]         = {3'b0, lid};
    o[ILAS_OCT_SCR_L*8 +: 8]       = {scr, 2'b0, 5'(num_lanes - 1)};
    o[ILAS_OCT_F*8 +: 8]           = 8'(f - 1);
    o[ILAS_OCT_K*8 +: 8]           = {3'b0, 5'(k - 1)};
    o[ILAS_OCT_M*8 +: 8]           = 8'(m - 1);
    o[ILAS_OCT_CS_N*8 +: 8]        = {2'b0, 1'b0, 5'(n - 1)};
    o[ILAS_OCT_SUBCLASS_NP*8 +: 8] = {subclassv, 5'(np - 1)};
    o[ILAS_OCT_JESDV_S*8 +: 8]     = {3'd1, 5'd0};
    o[ILAS_OCT_HD_CF*8 +: 8]       = {hd, 2'b0, 5'd0};
    o[ILAS_OCT_FCHK*8 +: 8]        = ilas_fchk(o);
    return o;
  endfunction

endpackage

// File: rtl/jesd204_rx_ilas_lane_check.sv
// ----------------------------------------------------------------------------
// jesd204_rx_ilas_lane_check
// Per-lane capture and check of the ILAS configuration octets.
//   IDLE -> CAPTURE on beat 0, beats must then arrive with consecutive
//   addresses up to the last beat (3 for DPW=4, 1 for DPW=8) -> CHECK (one
//   cycle, results registered) -> DONE. A new beat 0 restarts capture from
//   CAPTURE or DONE; an out-of-order beat in CAPTURE sets the sticky
//   seq_error and drops back to IDLE.
//
// Config macro: JESD204_RX_ILAS_LID_CHECK_EN - when defined LID[4:0] must
// equal LANE_INDEX; otherwise only octet 2 bits [7:5] are compared.
//
// Ports
//   clk, resetn      clock, async active-low reset
//   restart          sync clear of state and all flags
//   cfg_valid/addr   beat valid and beat index
//   cfg_data         DATA_PATH_WIDTH octets, octet 0 in LSBs
//   done             capture complete and checked
//   mismatch         OR of octet_mismatch
//   fchk_error       received FCHK differs from computed FCHK
//   seq_error        sticky out-of-order beat flag
//   octet_mismatch   per-octet mismatch mask, bit 13 = fchk_error
// ----------------------------------------------------------------------------
module jesd204_rx_ilas_lane_check
  import jesd204_ilas_pkg::*;
#(
  parameter int         NUM_LANES             = 1,
  parameter int         DATA_PATH_WIDTH       = 4,
  parameter logic [7:0] DID                   = 8'd0,
  parameter logic [3:0] BID                   = 4'd0,
  parameter int         OCTETS_PER_FRAME      = 1,
  parameter int         FRAMES_PER_MULTIFRAME = 32,
  parameter int         NUM_CONVERTERS        = 1,
  parameter int         N                     = 16,
  parameter int         NP                    = 16,
  parameter int         SCR                   = 1,
  parameter int         HIGH_DENSITY          = 1,
  parameter int         SUBCLASSV             = 1,
  parameter int         LANE_INDEX            = 0
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         restart,
  input  logic                         cfg_valid,
  input  logic [1:0]                   cfg_addr,
  input  logic [DATA_PATH_WIDTH*8-1:0] cfg_data,
  output logic                         done,
  output logic                         mismatch,
  output logic                         fchk_error,
  output logic                         seq_error,
  output logic [ILAS_NUM_OCTETS-1:0]   octet_mismatch
);

  localparam int         NUM_BEATS = (ILAS_NUM_OCTETS + DATA_PATH_WIDTH - 1) / DATA_PATH_WIDTH;
  localparam logic [1:0] LAST_ADDR = 2'(NUM_BEATS - 1);

  localparam ilas_octets_t EXP_OCTETS = ilas_build_octets(
    DID, BID, 5'(LANE_INDEX), NUM_LANES, OCTETS_PER_FRAME, FRAMES_PER_MULTIFRAME,
    NUM_CONVERTERS, N, NP, 1'(SCR), 1'(HIGH_DENSITY), 3'(SUBCLASSV));

`ifdef JESD204_RX_ILAS_LID_CHECK_EN
  localparam logic [7:0] LID_OCT_MASK = 8'hFF;
`else
  localparam logic [7:0] LID_OCT_MASK = 8'hE0;
`endif

  ilas_lane_state_e            state_reg;
  logic [1:0]                  exp_addr_reg;
  ilas_octets_t                rx_octets_reg;
  logic                        done_reg;
  logic                        mismatch_reg;
  logic                        fchk_error_reg;
  logic                        seq_error_reg;
  logic [ILAS_NUM_OCTETS-1:0]  octet_mismatch_reg;

  logic                        store_en;
  logic [7:0]                  fchk_calc;
  logic                        fchk_err_next;
  logic [ILAS_NUM_OCTETS-1:0]  octet_mismatch_next;

  // A beat is stored whenever the FSM accepts it: beat 0 from any state but
  // CHECK, or the expected next beat while capturing.
  always_comb begin
    store_en = 1'b0;
    if (cfg_valid) begin
      case (state_reg)
        ILAS_IDLE, ILAS_DONE: store_en = (cfg_addr == 2'd0);
        ILAS_CAPTURE:         store_en = (cfg_addr == 2'd0) || (cfg_addr == exp_addr_reg);
        default:              store_en = 1'b0;
      endcase
    end
  end

  // Only octets 0..13 are kept; trailing pad octets of the last beat drop out.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int i = 0; i < ILAS_NUM_OCTETS; i++) begin
        if (i / DATA_PATH_WIDTH == int'(cfg_addr)) begin
          rx_octets_reg[i*8 +: 8] <= cfg_data[(i % DATA_PATH_WIDTH)*8 +: 8];
        end
      end
    end
  end

  assign fchk_calc     = ilas_fchk(rx_octets_reg);
  assign fchk_err_next = (fchk_calc != rx_octets_reg[ILAS_OCT_FCHK*8 +: 8]);

  genvar gi;
  generate
    for (gi = 0; gi <= ILAS_OCT_HD_CF; gi++) begin : g_oct_cmp
      localparam logic [7:0] MASK = (gi == ILAS_OCT_LID) ? LID_OCT_MASK : 8'hFF;
      assign octet_mismatch_next[gi] =
        |((rx_octets_reg[gi*8 +: 8] ^ EXP_OCTETS[gi*8 +: 8]) & MASK);
    end
  endgenerate

  // Reserved octets are never flagged; the FCHK bit mirrors fchk_error.
  assign octet_mismatch_next[ILAS_OCT_RES1] = 1'b0;
  assign octet_mismatch_next[ILAS_OCT_RES2] = 1'b0;
  assign octet_mismatch_next[ILAS_OCT_FCHK] = fchk_err_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg          <= ILAS_IDLE;
      exp_addr_reg       <= 2'd0;
      done_reg           <= 1'b0;
      mismatch_reg       <= 1'b0;
      fchk_error_reg     <= 1'b0;
      seq_error_reg      <= 1'b0;
      octet_mismatch_reg <= '0;
    end else if (restart) begin
      state_reg          <= ILAS_IDLE;
      exp_addr_reg       <= 2'd0;
      done_reg           <= 1'b0;
      mismatch_reg       <= 1'b0;
      fchk_error_reg     <= 1'b0;
      seq_error_reg      <= 1'b0;
      octet_mismatch_reg <= '0;
    end else begin
      case (state_reg)
        ILAS_IDLE, ILAS_DONE: begin
          if (cfg_valid && cfg_addr == 2'd0) begin
            done_reg           <= 1'b0;
            mismatch_reg       <= 1'b0;
            fchk_error_reg     <= 1'b0;
            octet_mismatch_reg <= '0;
            exp_addr_reg       <= 2'd1;
            state_reg          <= ILAS_CAPTURE;
          end
        end
        ILAS_CAPTURE: begin
          if (cfg_valid) begin
            if (cfg_addr == 2'd0) begin
              exp_addr_reg <= 2'd1;
            end else if (cfg_addr == exp_addr_reg) begin
              if (cfg_addr == LAST_ADDR) begin
                state_reg <= ILAS_CHECK;
              end else begin
                exp_addr_reg <= 2'(exp_addr_reg + 2'd1);
              end
            end else begin
              seq_error_reg <= 1'b1;
              state_reg     <= ILAS_IDLE;
            end
          end
        end
        ILAS_CHECK: begin
          done_reg           <= 1'b1;
          mismatch_reg       <= |octet_mismatch_next;
          fchk_error_reg     <= fchk_err_next;
          octet_mismatch_reg <= octet_mismatch_next;
          state_reg          <= ILAS_DONE;
        end
        default: state_reg <= ILAS_IDLE;
      endcase
    end
  end

  assign done           = done_reg;
  assign mismatch       = mismatch_reg;
  assign fchk_error     = fchk_error_reg;
  assign seq_error      = seq_error_reg;
  assign octet_mismatch = octet_mismatch_reg;

endmodule

// File: rtl/jesd204_rx_ilas_cfg_check.sv
// ----------------------------------------------------------------------------
// jesd204_rx_ilas_cfg_check
// RX-side ILAS configuration checker. One independent lane checker per lane
// compares the captured configuration multiframe against the static link
// configuration given by the parameters and reports done/mismatch status.
// DATA_PATH_WIDTH must be 4 (4 beats) or 8 (2 beats).
//
// Config macro: JESD204_RX_ILAS_LID_CHECK_EN (enables LID == lane index check).
//
// Ports
//   clk, resetn          device clock, async active-low reset
//   restart              sync clear of all lanes and sticky flags
//   ilas_config_valid    per-lane beat valid
//   ilas_config_addr     per-lane 2-bit beat index
//   ilas_config_data     per-lane DATA_PATH_WIDTH octets, octet 0 in LSBs
//   ilas_done            per-lane capture+check complete
//   ilas_mismatch        per-lane any field mismatch or FCHK error
//   ilas_fchk_error      per-lane FCHK error
//   ilas_seq_error       per-lane sticky out-of-order beat
//   ilas_octet_mismatch  14 bits per lane, octet mismatch mask
// ----------------------------------------------------------------------------
module jesd204_rx_ilas_cfg_check
  import jesd204_ilas_pkg::*;
#(
  parameter int         NUM_LANES             = 1,
  parameter int         DATA_PATH_WIDTH       = 4,
  parameter logic [7:0] DID                   = 8'd0,
  parameter logic [3:0] BID                   = 4'd0,
  parameter int         OCTETS_PER_FRAME      = 1,
  parameter int         FRAMES_PER_MULTIFRAME = 32,
  parameter int         NUM_CONVERTERS        = 1,
  parameter int         N                     = 16,
  parameter int         NP                    = 16,
  parameter int         SCR                   = 1,
  parameter int         HIGH_DENSITY          = 1,
  parameter int         SUBCLASSV             = 1
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   restart,
  input  logic [NUM_LANES-1:0]                   ilas_config_valid,
  input  logic [2*NUM_LANES-1:0]                 ilas_config_addr,
  input  logic [NUM_LANES*DATA_PATH_WIDTH*8-1:0] ilas_config_data,
  output logic [NUM_LANES-1:0]                   ilas_done,
  output logic [NUM_LANES-1:0]                   ilas_mismatch,
  output logic [NUM_LANES-1:0]                   ilas_fchk_error,
  output logic [NUM_LANES-1:0]                   ilas_seq_error,
  output logic [ILAS_NUM_OCTETS*NUM_LANES-1:0]   ilas_octet_mismatch
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      jesd204_rx_ilas_lane_check #(
        .NUM_LANES             (NUM_LANES),
        .DATA_PATH_WIDTH       (DATA_PATH_WIDTH),
        .DID                   (DID),
        .BID                   (BID),
        .OCTETS_PER_FRAME      (OCTETS_PER_FRAME),
        .FRAMES_PER_MULTIFRAME (FRAMES_PER_MULTIFRAME),
        .NUM_CONVERTERS        (NUM_CONVERTERS),
        .N                     (N),
        .NP                    (NP),
        .SCR                   (SCR),
        .HIGH_DENSITY          (HIGH_DENSITY),
        .SUBCLASSV             (SUBCLASSV),
        .LANE_INDEX            (gi)
      ) u_lane (
        .clk            (clk),
        .resetn         (resetn),
        .restart        (restart),
        .cfg_valid      (ilas_config_valid[gi]),
        .cfg_addr       (ilas_config_addr[gi*2 +: 2]),
        .cfg_data       (ilas_config_data[gi*DATA_PATH_WIDTH*8 +: DATA_PATH_WIDTH*8]),
        .done           (ilas_done[gi]),
        .mismatch       (ilas_mismatch[gi]),
        .fchk_error     (ilas_fchk_error[gi]),
        .seq_error      (ilas_seq_error[gi]),
        .octet_mismatch (ilas_octet_mismatch[gi*ILAS_NUM_OCTETS +: ILAS_NUM_OCTETS])
      );
    end
  endgenerate

endmodule
